// File: rtl/axi_mst_wr_engine.sv
// axi_mst_wr_engine: single-outstanding AXI3 write burst master (AW, then W beats, then B).
// Define AXI_MST_WR_TIMEOUT_EN to add a 256-cycle watchdog on the write response.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready=1
// ADDR   | AWVALID held until AWREADY
// DATA   | streaming len+1 beats through the W output register
// RESP   | BREADY=1, waiting for BVALID (or watchdog expiry)
module axi_mst_wr_engine #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  output logic [ID_W-1:0]       AWID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [3:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ID_W-1:0]       WID,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_W-1:0]       BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_id_err,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] id_q;
  logic [3:0]      len_q;
  logic [4:0]      loaded;
  logic            cmd_fire;
  logic            wd_fire;
  logic            b_fire;
  logic            tmo_fire;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign BREADY    = (state == S_RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign b_fire    = BVALID && BREADY;
  // 5-bit compare so a 16-beat burst never wraps the beat counter
  assign wd_ready  = (state == S_DATA) && (loaded < ({1'b0, len_q} + 5'd1)) && (!WVALID || WREADY);
  assign wd_fire   = wd_valid && wd_ready;

`ifdef AXI_MST_WR_TIMEOUT_EN
  logic [8:0] tmo_cnt;

  // down-counter reloaded outside RESP; expires on the 256th RESP cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= 9'd0;
    end else if (state != S_RESP) begin
      tmo_cnt <= 9'd255;
    end else if (tmo_cnt != 9'd0) begin
      tmo_cnt <= tmo_cnt - 9'd1;
    end
  end

  assign tmo_fire = (state == S_RESP) && !b_fire && (tmo_cnt == 9'd0);
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      id_q       <= '0;
      len_q      <= '0;
      AWID       <= '0;
      AWADDR     <= '0;
      AWLEN      <= '0;
      AWSIZE     <= '0;
      AWBURST    <= '0;
      AWVALID    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_resp   <= 2'b00;
      rsp_id_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            id_q    <= cmd_id;
            len_q   <= cmd_len;
            AWID    <= cmd_id;
            AWADDR  <= cmd_addr;
            AWLEN   <= cmd_len;
            AWSIZE  <= cmd_size;
            AWBURST <= cmd_burst;
            AWVALID <= 1'b1;
            state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (WVALID && WREADY && WLAST) begin
            state <= S_RESP;
          end
        end
        default: begin
          if (b_fire || tmo_fire) begin
            rsp_valid  <= 1'b1;
            rsp_resp   <= b_fire ? BRESP : 2'b10;
            rsp_id_err <= b_fire && (BID != id_q);
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end

  // one-entry W output register; WVALID is purely registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded <= 5'd0;
      WID    <= '0;
      WDATA  <= '0;
      WSTRB  <= '0;
      WLAST  <= 1'b0;
      WVALID <= 1'b0;
    end else begin
      if (cmd_fire) begin
        loaded <= 5'd0;
      end else if (wd_fire) begin
        loaded <= loaded + 5'd1;
      end
      if (wd_fire) begin
        WDATA  <= wd_data;
        WSTRB  <= wd_strb;
        WID    <= id_q;
        WVALID <= 1'b1;
        WLAST  <= (loaded == {1'b0, len_q});
      end else if (WVALID && WREADY) begin
        WVALID <= 1'b0;
        WLAST  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_mst_wr_engine.sv
// Randomized self-checking bench for axi_mst_wr_engine against a beat-list reference model.
module tb_axi_mst_wr_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_strb = '0;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [3:0]  BID = '0;
  logic [1:0]  BRESP = '0;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic        rsp_id_err;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axi_mst_wr_engine #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_id_err(rsp_id_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0;
    wd_valid  = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
  endtask

  // wr_mode: 0 random ready/valid, 1 WREADY always high, 2 WREADY toggling
  // aw_delay < 0: random AWREADY; otherwise AWREADY low for aw_delay AWVALID cycles
  task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [1:0] bresp, input logic [3:0] bid,
                         input int aw_delay, input int wr_mode, input int stall_after,
                         input int stall_cyc, input int b_delay, input int rst_after);
    logic [31:0] dat [16];
    logic [3:0]  stb [16];
    logic [41:0] held_w;
    logic [1:0]  exp_resp;
    logic        exp_err;
    int src, wi, cyc, aw_cnt, resp_cyc, stall_left;
    bit accepted, acc_prev, aw_done, w_done, b_done, rsp_due, fin, held;
    bit aw_was, w_was, due_now;
    for (int i = 0; i < 16; i++) begin
      dat[i] = $urandom;
      stb[i] = 4'($urandom);
    end
    src = 0; wi = 0; cyc = 0; aw_cnt = 0; resp_cyc = 0; stall_left = stall_cyc;
    accepted = 0; acc_prev = 0; aw_done = 0; w_done = 0; b_done = 0;
    rsp_due = 0; fin = 0; held = 0; held_w = '0; exp_resp = 2'b00; exp_err = 1'b0;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_valid = !accepted;
      cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
      if (aw_delay < 0) AWREADY = AWVALID && ($urandom_range(0, 2) != 0);
      else              AWREADY = AWVALID && (aw_cnt >= aw_delay);
      case (wr_mode)
        0:       WREADY = ($urandom_range(0, 2) != 0);
        2:       WREADY = cyc[0];
        default: WREADY = 1'b1;
      endcase
      if (src <= int'(len)) begin
        wd_data = dat[src];
        wd_strb = stb[src];
        if (src == stall_after && stall_left > 0) begin
          wd_valid = 1'b0;
          stall_left--;
        end else begin
          wd_valid = (wr_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else begin
        wd_valid = 1'b0;
        wd_data  = $urandom;
      end
      if (!w_done) begin
        BVALID = ($urandom_range(0, 3) == 0);
        BRESP  = 2'b11;
        BID    = ~bid;
      end else if (!b_done) begin
        BVALID = (resp_cyc >= b_delay);
        BRESP  = bresp;
        BID    = bid;
      end else begin
        BVALID = 1'b0;
      end
      #1;
      due_now = rsp_due;
      rsp_due = 0;
      chk("rsp_valid", rsp_valid, due_now);
      if (due_now) begin
        chk("rsp_resp", rsp_resp, exp_resp);
        chk("rsp_id_err", rsp_id_err, exp_err);
        chk("busy_after_rsp", busy, 0);
        fin = 1;
      end else if (accepted) begin
        chk("cmd_stall", cmd_ready, 0);
      end
      if (acc_prev) chk("aw_start", AWVALID, 1);
      acc_prev = 0;
      if (!accepted && cmd_valid && cmd_ready) begin
        accepted = 1;
        acc_prev = 1;
      end
      aw_was = aw_done;
      if (AWVALID) begin
        if (aw_was) chk("aw_drop", AWVALID, 0);
        aw_cnt++;
        chk("aw_payload", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, {id, addr, len, size, burst});
        if (AWREADY) aw_done = 1;
      end
      w_was = w_done;
      if (WVALID && !aw_was) chk("w_before_aw", WVALID, 0);
      if (held) chk("w_hold", {WVALID, WID, WDATA, WSTRB, WLAST}, held_w);
      held   = WVALID && !WREADY;
      held_w = {WVALID, WID, WDATA, WSTRB, WLAST};
      if (WVALID && WREADY) begin
        if (wi > int'(len)) begin
          chk("w_extra_beat", 1, 0);
        end else begin
          chk("w_beat", {WID, WDATA, WSTRB, WLAST}, {id, dat[wi], stb[wi], wi == int'(len)});
          wi++;
          if (wi == int'(len) + 1) w_done = 1;
        end
      end
      if (wd_valid && wd_ready) src++;
      if (!w_was && BVALID) chk("bready_ignored", BREADY, 0);
      if (w_was && !b_done) begin
        resp_cyc++;
        if (BVALID && BREADY) begin
          b_done = 1; rsp_due = 1; exp_resp = bresp; exp_err = (bid != id);
`ifdef AXI_MST_WR_TIMEOUT_EN
        end else if (resp_cyc == 256) begin
          b_done = 1; rsp_due = 1; exp_resp = 2'b10; exp_err = 1'b0;
`endif
        end
      end
      if (rst_after > 0 && wi == rst_after) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ctrl", {AWVALID, WVALID, WLAST, BREADY, rsp_valid, rsp_id_err, rsp_resp, busy, cmd_ready},
            10'b0000_0000_01);
        chk("rst_aw", {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, 0);
        chk("rst_w", {WID, WDATA, WSTRB}, 0);
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (k == 2) rst = 1'b1;
          #1;
          chk("rst_no_rsp", {rsp_valid, busy}, 0);
        end
        fin = 1;
      end
    end
    if (!fin) chk("txn_cycle_budget", 0, 1);
    if (rst_after == 0 && aw_delay >= 0) chk("aw_cycles", aw_cnt, aw_delay + 1);
    idle_inputs();
  endtask

  initial begin
    logic [3:0] rid;
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", {AWVALID, WVALID, WLAST, BREADY, rsp_valid, rsp_id_err, rsp_resp, busy, cmd_ready},
        10'b0000_0000_01);
    chk("reset_payload", {AWID, AWADDR, WID, WDATA, WSTRB}, 0);
    @(negedge clk);
    rst = 1'b1;

    // single beat
    run_txn(4'd3, 32'h100, 4'd0, 3'd2, 2'd1, 2'b00, 4'd3, 0, 1, -1, 0, 0, 0);
    // AW and W backpressure
    run_txn(4'd9, 32'h2000, 4'd3, 3'd2, 2'd1, 2'b00, 4'd9, 5, 2, -1, 0, 1, 0);
    // source stall after beat 2
    run_txn(4'd1, 32'h3040, 4'd7, 3'd2, 2'd1, 2'b00, 4'd1, 0, 1, 2, 3, 0, 0);
    // BID mismatch
    run_txn(4'd5, 32'h44, 4'd1, 3'd2, 2'd1, 2'b01, 4'd6, 0, 1, -1, 0, 2, 0);
    // reset after beat 2, then a normal command
    run_txn(4'd7, 32'h500, 4'd3, 3'd2, 2'd1, 2'b00, 4'd7, 0, 1, -1, 0, 0, 2);
    run_txn(4'd2, 32'h600, 4'd3, 3'd2, 2'd1, 2'b00, 4'd2, 0, 1, -1, 0, 0, 0);
    // longest burst
    run_txn(4'd14, 32'h7000, 4'd15, 3'd2, 2'd1, 2'b00, 4'd14, 1, 0, -1, 0, 1, 0);
    // BVALID withheld for 300 RESP cycles: watchdog build times out, default build waits
    run_txn(4'd4, 32'h800, 4'd0, 3'd2, 2'd1, 2'b01, 4'd4, 0, 1, -1, 0, 300, 0);
    for (int t = 0; t < 30; t++) begin
      rid = 4'($urandom);
      run_txn(rid, $urandom, 4'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
              ($urandom_range(0, 3) == 0) ? ~rid : rid, -1, 0, -1, 0, $urandom_range(0, 6), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
